gf_mult_digit_serial: RTL and testbench
=======================================

# gf_mult_digit_serial

Digit-serial multiplier over GF(2^M), the parametrised sequential successor to the fixed 13-bit combinational GF(2^13) multiplier in the BCH decoder datapath. It computes a·b mod p(x) over ceil(M/D) clock cycles using D bits of b per cycle, and has an optional accumulate mode (result = a·b ⊕ previous result) for syndrome and key-equation updates. It sits between the syndrome/Euclidean control FSMs and shared register files, behind valid/ready handshakes, where area matters more than single-cycle latency.

## Interface
- M, 13: field degree; operands and result are M bits.
- POLY, 13'h001B: low M bits of the primitive polynomial, x^M implied. The default is x^13+x^4+x^3+x+1, the same field as the existing 13-bit multiplier.
- D, 4: digit width, 1..M. NDIG = ceil(M/D) cycles per product.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- in_a  in  M  multiplicand.
- in_b  in  M  multiplier, consumed D bits per cycle, MSB digit first.
- in_acc  in  1  1: XOR the new product into the held result; 0: plain product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_c  out  M  field product, or accumulated sum.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - latch a and b; zero-pad b at the top to NDIG·D bits;
    - clear the working accumulator w;
    - latch in_acc;
    - digit counter k=NDIG-1;
    - go to BUSY.
  - BUSY: each cycle, w ← (w·x^D mod p) ⊕ (a·b_k mod p), where b_k = bits [k·D+D-1 : k·D] of the padded b, then k ← k-1. After the k=0 step, go to DONE.
    - Final value: acc_latched ? (w ⊕ r) : w, written to result register r.
  - DONE: out_valid=1 and out_c=r, both held stable until out_valid&out_ready; then go to IDLE.
- r keeps its value after the handshake; it is the accumulate source for the next in_acc=1 operation.
- in_acc=1 as the first operation after reset accumulates into r=0.
- in_a and in_b are sampled only at acceptance; later changes have no effect.
- Inputs in BUSY/DONE are ignored (in_ready=0). No queueing, no back-to-back overlap.
- Arithmetic is pure GF(2): no carries. Every intermediate is reduced to M bits each cycle, so no wide products appear.
- D=M degenerates to a 1-cycle BUSY; D=1 is bit-serial (M cycles).
- Reset mid-operation: the operation is abandoned and the result is never emitted.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_c=0, r=0, w=0, k=0.
- Acceptance edge T; BUSY covers edges T+1..T+NDIG.
- out_valid rises after edge T+NDIG, a latency of NDIG cycles. M=13, D=4: 4 cycles.
- If out_ready=1 at the first out_valid cycle, the transfer completes at that edge and in_ready is high in the following cycle.
- Throughput is one product per NDIG+2 cycles.
- in_ready and out_valid are registered state decodes. There are no combinational paths from in_valid/out_ready to any output.

## Structure
- Shared package gf_pkg holds:
  - field constants (M, POLY defaults for the BCH code);
  - a function gf_mulx(v) returning v·x mod p;
  - the ceil-divide helper for NDIG.
- One sub-module, gf_digit_step: combinational, parametrised by M, POLY, D.
  - Computes (w·x^D ⊕ a·digit) mod p by D-fold unrolled shift-reduce.
  - It is the only combinational datapath; the top holds the FSM, counter and registers.

## Test plan
- Default params, a=0x1000, b=0x0002, acc=0: out_c=0x001B after exactly 4 cycles; in_ready low for 4 BUSY + 1 DONE cycle.
- a=0x1000, b=0x1000: out_c=0x185A (x^24 reduced). Repeat with D=1 (13 cycles) and D=13 (1 cycle): identical result.
- Accumulate: a=0x0001,b=0x0005,acc=0 gives 0x0005. Then a=0x0002,b=0x0003,acc=1 gives 0x0006⊕0x0005=0x0003.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid/out_c stay stable and in_valid pulses are ignored. Releasing out_ready transfers exactly once.
- Assert rst during the 2nd BUSY cycle: all outputs return to reset values immediately. The next in_acc=1 product of a=0x0003,b=0x0003 gives 0x0005 (r was cleared).
- Random regression: 10k random operand pairs across D∈{1,3,4,13}. Compare against a reference model of 13×13 carry-less multiply plus reduction by x^13+x^4+x^3+x+1.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions for the BCH datapath: default field, FSM encoding
// and small helpers used by the digit-serial multiplier.
package gf_pkg;

    localparam int GF_M = 13;
    localparam logic [GF_M-1:0] GF_POLY = 13'h001B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } gf_state_e;

    // v*x mod p in the default BCH field
    function automatic logic [GF_M-1:0] gf_mulx(input logic [GF_M-1:0] v);
        return {v[GF_M-2:0], 1'b0} ^ ({GF_M{v[GF_M-1]}} & GF_POLY);
    endfunction

    function automatic int gf_ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf_mult_digit_serial_if.sv
// Operand/result handshake bundle between the decoder control FSMs and the
// digit-serial multiplier.
interface gf_mult_digit_serial_if #(
    parameter int M = gf_pkg::GF_M
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_a;
    logic [M-1:0] in_b;
    logic         in_acc;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_c;

    modport master (
        output in_valid, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_c
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_c
    );
endinterface

// File: rtl/gf_digit_step.sv
// One digit of a digit-serial GF(2^M) product: (w*x^D xor a*digit) mod p,
// evaluated Horner-style MSB first so every intermediate stays M bits wide.
module gf_digit_step
    import gf_pkg::*;
#(
    parameter int          M    = GF_M,
    parameter logic [M-1:0] POLY = M'(GF_POLY),
    parameter int          D    = 4
) (
    input  logic [M-1:0] w,
    input  logic [M-1:0] a,
    input  logic [D-1:0] digit,
    output logic [M-1:0] w_next
);

    function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
        return (v << 1) ^ ({M{v[M-1]}} & POLY);
    endfunction

    always_comb begin
        w_next = w;
        for (int i = D - 1; i >= 0; i--) begin
            w_next = mulx(w_next) ^ ({M{digit[i]}} & a);
        end
    end

endmodule

// File: rtl/gf_mult_digit_serial.sv
// Digit-serial GF(2^M) multiplier with optional accumulate into the held
// result; one product every NDIG+2 cycles behind valid/ready handshakes.
module gf_mult_digit_serial
    import gf_pkg::*;
#(
    parameter int           M    = GF_M,
    parameter logic [M-1:0] POLY = M'(GF_POLY),
    parameter int           D    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    gf_mult_digit_serial_if.slave bus
);

    localparam int NDIG = gf_ceil_div(M, D);
    localparam int PADW = NDIG * D;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    gf_state_e state, state_nxt;

    logic [M-1:0]    a_q;
    logic [PADW-1:0] b_q;
    logic            acc_q;
    logic [M-1:0]    w_q;
    logic [M-1:0]    r_q;
    logic [KW-1:0]   k_q;
    logic [D-1:0]    digit;
    logic [M-1:0]    w_step;
    logic            accept;
    logic            last_step;

    assign accept    = (state == ST_IDLE) && bus.in_valid;
    assign last_step = (state == ST_BUSY) && (k_q == '0);
    assign digit     = b_q[int'(k_q) * D +: D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_nxt = ST_BUSY;
            ST_BUSY: if (k_q == '0)     state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
    end

    // Operands are captured only at acceptance; b is zero-padded at the top
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= bus.in_a;
            b_q   <= PADW'(bus.in_b);
            acc_q <= bus.in_acc;
        end
    end

    gf_digit_step #(
        .M    (M),
        .POLY (POLY),
        .D    (D)
    ) u_step (
        .w      (w_q),
        .a      (a_q),
        .digit  (digit),
        .w_next (w_step)
    );

    // r survives handshakes so the next accumulate op can fold into it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            k_q <= '0;
            r_q <= '0;
        end else if (accept) begin
            w_q <= '0;
            k_q <= K_LAST;
        end else if (state == ST_BUSY) begin
            w_q <= w_step;
            if (k_q != '0) begin
                k_q <= k_q - KW'(1);
            end
            if (last_step) begin
                r_q <= acc_q ? (w_step ^ r_q) : w_step;
            end
        end
    end

    assign bus.out_c = r_q;

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_c)));

    a_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_gf_mult_digit_serial.sv
// Bench for gf_mult_digit_serial: four instances (D = 1, 3, 4, 13) driven in
// lockstep and compared against a carry-less multiply + polynomial reduction model.
module tb_gf_mult_digit_serial;
    import gf_pkg::*;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_acc = 1'b0;
    logic        out_ready = 1'b0;
    logic [12:0] in_a = '0;
    logic [12:0] in_b = '0;

    int dval[NDUT] = '{1, 3, 4, 13};
    int ndig[NDUT] = '{13, 5, 4, 1};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [12:0] r_model = '0;

    always #5 clk = ~clk;

    gf_mult_digit_serial_if #(.M(13)) bus1 ();
    gf_mult_digit_serial_if #(.M(13)) bus3 ();
    gf_mult_digit_serial_if #(.M(13)) bus4 ();
    gf_mult_digit_serial_if #(.M(13)) bus13 ();

    assign bus1.in_valid  = in_valid;  assign bus1.in_a  = in_a;  assign bus1.in_b  = in_b;
    assign bus1.in_acc    = in_acc;    assign bus1.out_ready  = out_ready;
    assign bus3.in_valid  = in_valid;  assign bus3.in_a  = in_a;  assign bus3.in_b  = in_b;
    assign bus3.in_acc    = in_acc;    assign bus3.out_ready  = out_ready;
    assign bus4.in_valid  = in_valid;  assign bus4.in_a  = in_a;  assign bus4.in_b  = in_b;
    assign bus4.in_acc    = in_acc;    assign bus4.out_ready  = out_ready;
    assign bus13.in_valid = in_valid;  assign bus13.in_a = in_a;  assign bus13.in_b = in_b;
    assign bus13.in_acc   = in_acc;    assign bus13.out_ready = out_ready;

    logic        rdy[NDUT];
    logic        vld[NDUT];
    logic [12:0] oc[NDUT];

    assign rdy[0] = bus1.in_ready;  assign vld[0] = bus1.out_valid;  assign oc[0] = bus1.out_c;
    assign rdy[1] = bus3.in_ready;  assign vld[1] = bus3.out_valid;  assign oc[1] = bus3.out_c;
    assign rdy[2] = bus4.in_ready;  assign vld[2] = bus4.out_valid;  assign oc[2] = bus4.out_c;
    assign rdy[3] = bus13.in_ready; assign vld[3] = bus13.out_valid; assign oc[3] = bus13.out_c;

    gf_mult_digit_serial #(.M(13), .POLY(GF_POLY), .D(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    gf_mult_digit_serial #(.M(13), .POLY(GF_POLY), .D(3))  dut3  (.clk(clk), .rst(rst), .bus(bus3));
    gf_mult_digit_serial #(.M(13), .POLY(GF_POLY), .D(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    gf_mult_digit_serial #(.M(13), .POLY(GF_POLY), .D(13)) dut13 (.clk(clk), .rst(rst), .bus(bus13));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Full 25-bit carry-less product, then long division by x^13+x^4+x^3+x+1
    function automatic logic [12:0] ref_mul(input logic [12:0] a, input logic [12:0] b);
        logic [24:0] p;
        p = '0;
        for (int i = 0; i < 13; i++) begin
            if (b[i]) p = p ^ (25'(a) << i);
        end
        for (int i = 24; i >= 13; i--) begin
            if (p[i]) p = p ^ (25'h201B << (i - 13));
        end
        return p[12:0];
    endfunction

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_ready_d%0d", tag, dval[i]), 32'(rdy[i]), 32'd1);
            check($sformatf("%s_valid_d%0d", tag, dval[i]), 32'(vld[i]), 32'd0);
            check($sformatf("%s_outc_d%0d", tag, dval[i]), 32'(oc[i]), 32'd0);
        end
    endtask

    task automatic check_all_outc(input string tag, input logic [12:0] exp);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_d%0d", tag, dval[i]), 32'(oc[i]), 32'(exp));
        end
    endtask

    // Called #1 after a clock edge with all instances idle and out_ready low.
    task automatic run_op(input string tag, input logic [12:0] a, input logic [12:0] b,
                          input logic acc, input int hold);
        int          lat[NDUT];
        logic [12:0] exp;
        bit          all_seen;
        exp = ref_mul(a, b) ^ (acc ? r_model : 13'h0);
        in_valid = 1'b1; in_a = a; in_b = b; in_acc = acc;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 13'($urandom); in_b = 13'($urandom); in_acc = 1'($urandom);
        for (int i = 0; i < NDUT; i++) lat[i] = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            all_seen = 1'b1;
            for (int i = 0; i < NDUT; i++) begin
                if (vld[i] && lat[i] < 0) lat[i] = cyc;
                if (lat[i] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_lat_d%0d", tag, dval[i]), 32'(lat[i]), 32'(ndig[i]));
            check($sformatf("%s_outc_d%0d", tag, dval[i]), 32'(oc[i]), 32'(exp));
        end
        r_model = exp;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); in_a = 13'($urandom); in_b = 13'($urandom); in_acc = 1'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("%s_hold_valid_d%0d", tag, dval[i]), 32'(vld[i]), 32'd1);
                check($sformatf("%s_hold_ready_d%0d", tag, dval[i]), 32'(rdy[i]), 32'd0);
                check($sformatf("%s_hold_outc_d%0d", tag, dval[i]), 32'(oc[i]), 32'(exp));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_post_valid_d%0d", tag, dval[i]), 32'(vld[i]), 32'd0);
            check($sformatf("%s_post_ready_d%0d", tag, dval[i]), 32'(rdy[i]), 32'd1);
        end
    endtask

    function automatic logic [12:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 13'h0000;
            1:       return 13'h0001;
            2:       return 13'h1FFF;
            default: return 13'($urandom);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lowcnt;
        logic [12:0] cap;
        bit          idle;

        #2;
        check_reset_state("rst_init");
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // x^12 * x = x^13 with out_ready already high: 4 BUSY + 1 DONE cycle for D=4
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 13'h1000; in_b = 13'h0002; in_acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lowcnt = 0; cap = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (rdy[2]) break;
            lowcnt++;
            if (vld[2]) cap = oc[2];
            @(posedge clk); #1;
        end
        check("busy_done_cycles_d4", 32'(lowcnt), 32'd5);
        check("x13_captured_d4", 32'(cap), 32'h001B);
        idle = 1'b0;
        for (int cyc = 0; cyc < 30 && !idle; cyc++) begin
            idle = rdy[0] && rdy[1] && rdy[2] && rdy[3];
            if (!idle) begin @(posedge clk); #1; end
        end
        check("all_idle_after_x13", 32'(idle), 32'd1);
        out_ready = 1'b0;
        check_all_outc("x13_held", 13'h001B);
        r_model = 13'h001B;

        run_op("x24", 13'h1000, 13'h1000, 1'b0, 0);
        check_all_outc("x24_const", 13'h185A);

        run_op("acc_first", 13'h0001, 13'h0005, 1'b0, 1);
        check_all_outc("acc_first_const", 13'h0005);
        run_op("acc_second", 13'h0002, 13'h0003, 1'b1, 0);
        check_all_outc("acc_second_const", 13'h0003);

        run_op("backpressure", 13'($urandom), 13'($urandom), 1'b0, 10);
        repeat (3) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++)
                check($sformatf("bp_once_valid_d%0d", dval[i]), 32'(vld[i]), 32'd0);
        end

        // Reset lands in the second BUSY cycle; the product must never appear
        in_valid = 1'b1; in_a = 13'h1234; in_b = 13'h0ABC; in_acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("rst_after");
        r_model = '0;
        run_op("acc_after_rst", 13'h0003, 13'h0003, 1'b1, 0);
        check_all_outc("acc_after_rst_const", 13'h0005);

        for (int n = 0; n < 2500; n++) begin
            run_op("rand", pick_operand(), pick_operand(), ($urandom_range(0, 2) == 0),
                   $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
